// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - response checker for 2-input gate test fixtures
module gate_response_checker #(
   parameter int GATE_OP    = 0,
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             vec_valid_i,
   input  logic             a_i,
   input  logic             b_i,
   input  logic             z_i,
   output logic             vec_ready_o,
   output logic [CNT_W-1:0] pass_cnt_o,
   output logic [CNT_W-1:0] fail_cnt_o,
   output logic [2:0]       first_fail_o,
   output logic             first_fail_vld_o,
   output logic [3:0]       coverage_o,
   output logic             error_o,
   output logic             done_o
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARMED  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [7:0]       SETTLE_LOAD = (SETTLE_CYC > 0) ? 8'(SETTLE_CYC - 1) : 8'd0;

   state_t           state_q;
   logic [7:0]       settle_q;
   logic [1:0]       ab_q;
   logic [CNT_W-1:0] pass_q;
   logic [CNT_W-1:0] fail_q;
   logic [2:0]       ff_q;
   logic             ffv_q;
   logic [3:0]       cov_q;
   logic             err_q;
   logic             done_q;
   logic             ready_q;

   logic             expect_d;
   logic             match_d;
   logic [3:0]       cov_d;

   // Expected gate output for the captured vector and coverage including it
   always_comb begin
      expect_d = 1'b0;
      case (GATE_OP)
         0:       expect_d = ab_q[1] & ab_q[0];
         1:       expect_d = ab_q[1] | ab_q[0];
         2:       expect_d = ab_q[1] ^ ab_q[0];
         default: expect_d = ~(ab_q[1] & ab_q[0]);
      endcase
      match_d = (z_i == expect_d);
      cov_d   = cov_q | (4'b0001 << ab_q);
   end

   // Checker FSM: accept vector, wait settle time, compare z, accumulate results
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         settle_q <= 8'd0;
         ab_q     <= 2'b00;
         pass_q   <= '0;
         fail_q   <= '0;
         ff_q     <= 3'b000;
         ffv_q    <= 1'b0;
         cov_q    <= 4'b0000;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b0;
      end else if (start_i) begin
         // start wins over any in-flight check and over a same-cycle vector
         state_q  <= ST_ARMED;
         settle_q <= 8'd0;
         pass_q   <= '0;
         fail_q   <= '0;
         ff_q     <= 3'b000;
         ffv_q    <= 1'b0;
         cov_q    <= 4'b0000;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               ready_q <= 1'b0;
            end
            ST_ARMED: begin
               if (vec_valid_i) begin
                  ab_q    <= {a_i, b_i};
                  ready_q <= 1'b0;
                  if (SETTLE_CYC > 0) begin
                     state_q  <= ST_SETTLE;
                     settle_q <= SETTLE_LOAD;
                  end else begin
                     state_q <= ST_CHECK;
                  end
               end
            end
            ST_SETTLE: begin
               if (settle_q == 8'd0) begin
                  state_q <= ST_CHECK;
               end else begin
                  settle_q <= settle_q - 8'd1;
               end
            end
            ST_CHECK: begin
               cov_q <= cov_d;
               if (match_d) begin
                  if (pass_q != CNT_MAX) pass_q <= pass_q + 1'b1;
               end else begin
                  if (fail_q != CNT_MAX) fail_q <= fail_q + 1'b1;
                  err_q <= 1'b1;
                  if (!ffv_q) begin
                     ff_q  <= {ab_q, z_i};
                     ffv_q <= 1'b1;
                  end
               end
               if (cov_d == 4'hF) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ST_ARMED;
                  ready_q <= 1'b1;
               end
            end
            ST_DONE: begin
               ready_q <= 1'b0;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign vec_ready_o      = ready_q;
   assign pass_cnt_o       = pass_q;
   assign fail_cnt_o       = fail_q;
   assign first_fail_o     = ff_q;
   assign first_fail_vld_o = ffv_q;
   assign coverage_o       = cov_q;
   assign error_o          = err_q;
   assign done_o           = done_q;

endmodule
